// File: rtl/regfile_wb_sched_pkg.sv
// Shared types for the register-file writeback scheduler.
//   src_e     : writeback source index (load, ALU, base-address increment)
//   prio_e    : priority order handed to the picker
//   wb_req_t  : one writeback request {valid, addr, data}
//   pick_req  : returns one of three requests, chosen by source index
package regfile_wb_sched_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  typedef enum logic [1:0] {
    SRC_LD  = 2'd0,
    SRC_ALU = 2'd1,
    SRC_INC = 2'd2
  } src_e;

  // Any encoding other than PRIO_LD_INC_ALU falls back to the default order.
  typedef enum logic [1:0] {
    PRIO_LD_ALU_INC = 2'd0,
    PRIO_LD_INC_ALU = 2'd1
  } prio_e;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } wb_req_t;

  function automatic wb_req_t pick_req(input src_e s, input wb_req_t ld,
                                       input wb_req_t alu, input wb_req_t inc);
    case (s)
      SRC_LD:  return ld;
      SRC_ALU: return alu;
      SRC_INC: return inc;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/regfile_wb_sched_if.sv
// Writeback bus between the three pipeline sources and the register file.
//   ld_* / alu_* / inc_* : valid/ready request handshakes with address and data
//   wen0/1, waddr0/1, wdata0/1 : register-file write ports
//   drop_cnt : saturating count of collision-dropped writes
// Modports: master = pipeline/register-file side, slave = scheduler.
interface regfile_wb_sched_if;
  import regfile_wb_sched_pkg::*;

  logic                  ld_valid,  ld_ready;
  logic [REG_ADDR_W-1:0] ld_addr;
  logic [XLEN-1:0]       ld_data;
  logic                  alu_valid, alu_ready;
  logic [REG_ADDR_W-1:0] alu_addr;
  logic [XLEN-1:0]       alu_data;
  logic                  inc_valid, inc_ready;
  logic [REG_ADDR_W-1:0] inc_addr;
  logic [XLEN-1:0]       inc_data;

  logic                  wen0, wen1;
  logic [REG_ADDR_W-1:0] waddr0, waddr1;
  logic [XLEN-1:0]       wdata0, wdata1;
  logic [7:0]            drop_cnt;

  modport master (
    output ld_valid, ld_addr, ld_data,
    output alu_valid, alu_addr, alu_data,
    output inc_valid, inc_addr, inc_data,
    input  ld_ready, alu_ready, inc_ready,
    input  wen0, waddr0, wdata0, wen1, waddr1, wdata1, drop_cnt
  );

  modport slave (
    input  ld_valid, ld_addr, ld_data,
    input  alu_valid, alu_addr, alu_data,
    input  inc_valid, inc_addr, inc_data,
    output ld_ready, alu_ready, inc_ready,
    output wen0, waddr0, wdata0, wen1, waddr1, wdata1, drop_cnt
  );

endinterface

// File: rtl/regfile_wb_sched_wb_prio_pick.sv
// Combinational selection of up to two writes among three requests.
//   req_ld_i, req_alu_i, req_inc_i : incoming requests
//   prio_i   : priority order (ld>alu>inc or ld>inc>alu)
//   grant_o  : per-source ready, indexed by src_e
//   port0_o  : request issued on write port 0 (valid = issue)
//   port1_o  : request issued on write port 1 (valid = issue)
//   drop_o   : a granted write was discarded due to an address collision
module wb_prio_pick
  import regfile_wb_sched_pkg::*;
(
  input  wb_req_t    req_ld_i,
  input  wb_req_t    req_alu_i,
  input  wb_req_t    req_inc_i,
  input  prio_e      prio_i,
  output logic [2:0] grant_o,
  output wb_req_t    port0_o,
  output wb_req_t    port1_o,
  output logic       drop_o
);

  wb_req_t    req [3];
  src_e       ord [3];
  logic [1:0] slots;

  always_comb begin
    req[SRC_LD]  = req_ld_i;
    req[SRC_ALU] = req_alu_i;
    req[SRC_INC] = req_inc_i;

    ord[0] = SRC_LD;
    if (prio_i == PRIO_LD_INC_ALU) begin
      ord[1] = SRC_INC;
      ord[2] = SRC_ALU;
    end else begin
      ord[1] = SRC_ALU;
      ord[2] = SRC_INC;
    end

    grant_o = '0;
    port0_o = '0;
    port1_o = '0;
    drop_o  = 1'b0;
    slots   = '0;

    // r0 writes are consumed without taking a slot, so a stalled source
    // can use the freed slot. A collided write still takes its slot but
    // not a port; only one drop is possible per cycle.
    for (int i = 0; i < 3; i++) begin
      if (req[ord[i]].valid) begin
        if (req[ord[i]].addr == '0) begin
          grant_o[ord[i]] = 1'b1;
        end else if (slots != 2'd2) begin
          grant_o[ord[i]] = 1'b1;
          if (slots == 2'd0) begin
            port0_o = req[ord[i]];
          end else if (req[ord[i]].addr == port0_o.addr) begin
            drop_o = 1'b1;
          end else begin
            port1_o = req[ord[i]];
          end
          slots = slots + 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_wb_sched.sv
// Writeback scheduler in front of the register file's two write ports.
//   clk, rst : clock and synchronous active-high reset
//   bus      : request handshakes in, registered write ports and drop count out
// STARVE_LIMIT (1..15): stalled cycles of the increment source before it is
// promoted above the ALU.
module regfile_wb_sched
  import regfile_wb_sched_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic              clk,
  input logic              rst,
  regfile_wb_sched_if.slave bus
);

  wb_req_t    req_ld, req_alu, req_inc;
  wb_req_t    port0, port1;
  logic [2:0] grant;
  logic       drop;
  prio_e      prio;
  logic       boost;

  logic [3:0]            starve_q, starve_d;
  logic [7:0]            drop_q, drop_d;
  logic                  wen0_q, wen1_q;
  logic [REG_ADDR_W-1:0] waddr0_q, waddr1_q;
  logic [XLEN-1:0]       wdata0_q, wdata1_q;

  assign req_ld  = {bus.ld_valid,  bus.ld_addr,  bus.ld_data};
  assign req_alu = {bus.alu_valid, bus.alu_addr, bus.alu_data};
  assign req_inc = {bus.inc_valid, bus.inc_addr, bus.inc_data};

  // Promote in the cycle that would be the STARVE_LIMIT-th stalled one.
  assign boost = bus.inc_valid && ((32'(starve_q) + 32'd1) >= STARVE_LIMIT);
  assign prio  = boost ? PRIO_LD_INC_ALU : PRIO_LD_ALU_INC;

  wb_prio_pick u_pick (
    .req_ld_i  (req_ld),
    .req_alu_i (req_alu),
    .req_inc_i (req_inc),
    .prio_i    (prio),
    .grant_o   (grant),
    .port0_o   (port0),
    .port1_o   (port1),
    .drop_o    (drop)
  );

  assign bus.ld_ready  = grant[SRC_LD]  & ~rst;
  assign bus.alu_ready = grant[SRC_ALU] & ~rst;
  assign bus.inc_ready = grant[SRC_INC] & ~rst;

  always_comb begin
    starve_d = '0;
    if (bus.inc_valid && !grant[SRC_INC])
      starve_d = (starve_q == 4'hF) ? starve_q : starve_q + 4'd1;
    drop_d = drop_q;
    if (drop && drop_q != 8'hFF)
      drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
      drop_q   <= '0;
      wen0_q   <= 1'b0;
      wen1_q   <= 1'b0;
      waddr0_q <= '0;
      waddr1_q <= '0;
      wdata0_q <= '0;
      wdata1_q <= '0;
    end else begin
      starve_q <= starve_d;
      drop_q   <= drop_d;
      wen0_q   <= port0.valid;
      wen1_q   <= port1.valid;
      if (port0.valid) begin
        waddr0_q <= port0.addr;
        wdata0_q <= port0.data;
      end
      if (port1.valid) begin
        waddr1_q <= port1.addr;
        wdata1_q <= port1.data;
      end
    end
  end

  assign bus.wen0     = wen0_q;
  assign bus.waddr0   = waddr0_q;
  assign bus.wdata0   = wdata0_q;
  assign bus.wen1     = wen1_q;
  assign bus.waddr1   = waddr1_q;
  assign bus.wdata1   = wdata1_q;
  assign bus.drop_cnt = drop_q;

endmodule
